// File: rtl/wave_seq_pkg.sv
// wave_seq_pkg: shared state encoding and default widths for the triangle sequencer
package wave_seq_pkg;
   localparam int WIDTH_D  = 5;
   localparam int CNT_W_D  = 8;
   localparam int HOLD_W_D = 4;
   typedef enum logic [2:0] {IDLE, RISE, HOLD_HI, FALL, HOLD_LO, DONE} state_t;
endpackage

// File: rtl/wave_sat_step.sv
// wave_sat_step: saturating step toward hi (up) and toward lo (dn) without wrap
module wave_sat_step
   import wave_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_D
) (
   input  logic [WIDTH-1:0] wave,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] step,
   output logic [WIDTH-1:0] up,
   output logic [WIDTH-1:0] dn
);
   logic [WIDTH:0] sum, diff;
   always_comb begin
      sum  = {1'b0, wave} + {1'b0, step};
      diff = {1'b0, wave} - {1'b0, lo};
      up   = sum > {1'b0, hi} ? hi : sum[WIDTH-1:0];
      dn   = diff < {1'b0, step} ? lo : wave - step;
   end
endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer: configurable triangle wave generator with dwell, period count and graceful stop
module wave_sequencer
   import wave_seq_pkg::*;
#(
   parameter int WIDTH  = WIDTH_D,
   parameter int CNT_W  = CNT_W_D,
   parameter int HOLD_W = HOLD_W_D
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WIDTH-1:0]  cfg_lo,
   input  logic [WIDTH-1:0]  cfg_hi,
   input  logic [WIDTH-1:0]  cfg_step,
   input  logic [HOLD_W-1:0] cfg_hold,
   input  logic [CNT_W-1:0]  cfg_periods,
   input  logic              stop,
   output logic [WIDTH-1:0]  wave,
   output logic              busy,
   output logic              period_tick,
   output logic              done,
   output logic              err
);
   state_t state, state_nx;
   logic [WIDTH-1:0] lo_r, hi_r, step_r, up, dn;
   logic [HOLD_W-1:0] hold_r, dwell;
   logic [CNT_W-1:0] per_r, cnt, cnt_nx;
   logic stop_pending, accept, bad, at_hi, at_lo, last;

   wave_sat_step #(.WIDTH(WIDTH)) u_step (
      .wave(wave), .lo(lo_r), .hi(hi_r), .step(step_r), .up(up), .dn(dn)
   );

   always_comb begin
      accept = cfg_valid && cfg_ready;
      bad    = cfg_lo > cfg_hi || cfg_step == '0;
      at_hi  = wave == hi_r;
      at_lo  = wave == lo_r;
      cnt_nx = &cnt ? cnt : cnt + 1'b1;
      // a stop arriving in the very cycle the period completes still ends the run
      last   = stop_pending || stop || (per_r != '0 && cnt_nx == per_r);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (accept && !bad) state_nx = RISE;
         RISE:       if (at_hi) state_nx = hold_r != '0 ? HOLD_HI : FALL;
         HOLD_HI:    if (dwell == HOLD_W'(1)) state_nx = FALL;
         FALL:       if (at_lo) state_nx = last ? DONE : hold_r != '0 ? HOLD_LO : RISE;
         HOLD_LO:    if (dwell == HOLD_W'(1)) state_nx = RISE;
         default:    state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy      = state inside {RISE, HOLD_HI, FALL, HOLD_LO};
      done      = state == DONE;
      cfg_ready = state == IDLE || state == DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wave         <= '0;
         lo_r         <= '0;
         hi_r         <= '0;
         step_r       <= '0;
         hold_r       <= '0;
         per_r        <= '0;
         dwell        <= '0;
         cnt          <= '0;
         stop_pending <= 1'b0;
         period_tick  <= 1'b0;
         err          <= 1'b0;
      end else begin
         err         <= accept && bad;
         period_tick <= state == FALL && at_lo;
         if (accept && !bad) begin
            lo_r   <= cfg_lo;
            hi_r   <= cfg_hi;
            step_r <= cfg_step;
            hold_r <= cfg_hold;
            per_r  <= cfg_periods;
            wave   <= cfg_lo;
            cnt    <= '0;
         end else if (state == RISE && !at_hi) wave <= up;
         else if (state == FALL && !at_lo) wave <= dn;
         if ((state == RISE && at_hi) || (state == FALL && at_lo)) dwell <= hold_r;
         else if (state == HOLD_HI || state == HOLD_LO) dwell <= dwell - 1'b1;
         if (state == FALL && at_lo) cnt <= cnt_nx;
         if (state_nx == DONE || !busy) stop_pending <= 1'b0;
         else stop_pending <= stop_pending || stop;
      end
   end
endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
Programmable controller and datapath for the 5-bit triangle waveform output. It accepts a configuration via a valid/ready handshake: low/high bounds, step size, dwell at each extreme, and number of periods. It then sequences the rise/dwell/fall cycle and stops after N periods, or gracefully on request. It sits between the control/register layer and the downstream DAC/wave consumer.

Parameters:
WIDTH, 5, wave sample width
CNT_W, 8, period counter width; cfg_periods==0 means run until stop
HOLD_W, 4, dwell counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration accepted when cfg_valid&&cfg_ready
cfg_lo  input  WIDTH  lower bound
cfg_hi  input  WIDTH  upper bound
cfg_step  input  WIDTH  increment/decrement per cycle
cfg_hold  input  HOLD_W  extra dwell cycles at each extreme
cfg_periods  input  CNT_W  periods to generate; 0 = continuous
stop  input  1  request graceful stop at end of current period
wave  output  WIDTH  waveform sample (registered)
busy  output  1  sequence running
period_tick  output  1  one-cycle pulse per completed period
done  output  1  level; sequence finished, cleared by next accepted config
err  output  1  one-cycle pulse; rejected config

Behaviour:
- Reset values: wave=0, busy=0, done=0, period_tick=0, err=0, cfg_ready=1, state IDLE, counters 0, stop_pending=0. A reset mid-sequence aborts immediately to these values.
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO, DONE.
- cfg_ready=1 only in IDLE and DONE. cfg_valid while busy is ignored and does not disturb the run.
- On accept:
  - If cfg_lo>cfg_hi or cfg_step==0: err=1 for the next cycle, state unchanged, wave unchanged, config discarded.
  - Otherwise: latch config, clear done, period count=0. Next cycle: wave=lo, busy=1, state RISE.
- RISE:
  - wave==hi: go to HOLD_HI (dwell=cfg_hold) if cfg_hold!=0, else FALL. wave unchanged.
  - Otherwise: wave <= min(wave+step, hi). Compute in WIDTH+1 bits; the value never wraps.
- HOLD_HI: decrement dwell each cycle; when dwell==1, go to FALL. wave stays hi. Net effect: wave reads hi for exactly cfg_hold+2 cycles.
- FALL:
  - wave!=lo: wave <= (wave-lo < step) ? lo : wave-step. The value never underflows.
  - wave==lo: period complete.
    - period_tick=1 next cycle; period count increments, saturating at max.
    - If stop_pending, or cfg_periods!=0 and the new count==cfg_periods: go to DONE.
    - Else go to HOLD_LO if cfg_hold!=0, else RISE.
- HOLD_LO: mirrors HOLD_HI, exits to RISE. wave reads lo for cfg_hold+2 cycles between periods.
- DONE:
  - Signals: wave holds lo, busy=0, done=1, cfg_ready=1.
  - Timing: period_tick for the final period coincides with the first DONE cycle.
- stop:
  - Sampled in RISE/HOLD_HI/FALL/HOLD_LO; sets stop_pending, cleared on entering DONE.
  - Ignored in IDLE/DONE.
  - stop asserted in the same cycle FALL observes lo takes effect on that period.
- lo==hi is legal: wave constant. The period is 2 cycles at hold=0, and ticks and counts still apply.
- Period length at hold=0: 2*ceil((hi-lo)/step)+2 cycles. Example lo=0, hi=3, step=1: 0,1,2,3,3,2,1,0 repeating.

Decomposition:
- Package wave_seq_pkg: state enum (6 states), default WIDTH/CNT_W/HOLD_W constants.
- One natural sub-module, wave_sat_step: combinational saturating add-toward-hi / subtract-toward-lo on WIDTH+1 bits. The FSM, counters and handshake remain in wave_sequencer.

Test Plan:
- Reset then config lo=0, hi=31, step=1, hold=0, periods=1:
  - wave 0..31, 31, 30..0.
  - period_tick once, coinciding with done=1.
  - busy high from cycle after accept through the last FALL cycle.
- lo=0, hi=3, step=1, hold=0, periods=2: wave=0,1,2,3,3,2,1,0,0,1,2,3,3,2,1,0 then holds 0; exactly 2 period_tick pulses, 8 cycles apart.
- lo=4, hi=20, step=5, hold=2, periods=1:
  - Rise: 4,9,14,19,20.
  - Hold: 20 visible 4 cycles.
  - Fall: 15,10,5,4 (saturate at lo).
  - done=1.
- periods=0, lo=0, hi=7, step=2: runs continuously. Pulse stop mid-rise -> finishes the current period at 0, then DONE; a second stop in DONE has no effect.
- Config lo=10, hi=5 -> err pulse, done/busy stay 0, wave unchanged. cfg_step=0 -> err pulse. cfg_valid during busy -> cfg_ready=0, waveform unaffected.
- Assert rst_n low mid-FALL at wave=17 -> wave=0, busy=0, done=0, cfg_ready=1 immediately (asynchronous); a new config after release starts cleanly.
